// File: rtl/gray_conv_arbiter_pkg.sv
// Purpose : shared definitions for the Gray-decode arbiter and other code converters.
// Latency : n/a (types, constants and a combinational helper function only).
// Backpr. : n/a.
//
// Contents:
//   state_e     FSM state encoding of the arbiter (IDLE / CONV / OUT)
//   GRAY_MAX_W  widest word the gray2bin helper handles
//   gray2bin    Gray -> binary decode of a word zero-extended to GRAY_MAX_W bits
package gray_conv_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CONV = 2'd1,
      ST_OUT  = 2'd2
   } state_e;

   localparam int GRAY_MAX_W = 32;

   // Zero-extending a narrower Gray word keeps its decode intact: leading
   // zeros contribute nothing to the running XOR, so callers may pass any
   // width up to GRAY_MAX_W and take the low bits of the result.
   function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
      logic [GRAY_MAX_W-1:0] b;
      b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
      for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/gray_conv_arbiter_decode.sv
// Purpose : combinational Gray -> binary decode (MSB-first XOR prefix chain).
// Latency : 0 cycles, purely combinational.
// Backpr. : none; no handshake, output follows input.
//
// Ports:
//   gray_i  [WIDTH-1:0]  Gray-coded word
//   bin_o   [WIDTH-1:0]  binary equivalent
module gray_decode_core #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] gray_i,
   output logic [WIDTH-1:0] bin_o
);

   // A local accumulator keeps the chain inside one process, so the
   // bit-to-bit dependency never shows up as a combinational loop on bin_o.
   logic [WIDTH-1:0] acc;

   always_comb begin
      acc            = '0;
      acc[WIDTH-1]   = gray_i[WIDTH-1];
      for (int i = WIDTH - 2; i >= 0; i--) begin
         acc[i] = acc[i+1] ^ gray_i[i];
      end
      bin_o = acc;
   end

endmodule

// File: rtl/gray_conv_arbiter.sv
// Purpose : round-robin shares one Gray->binary decoder between N_REQ requesters.
// Latency : request accepted at edge T -> out_valid registered at edge T+1 (seen the cycle after CONV);
//           at most one result every 3 cycles.
// Backpr. : out_ready low stalls the FSM in OUT with outputs frozen; req_ready stays 0 meanwhile.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   req_valid  [N_REQ]        per-requester request valid
//   req_gray   [N_REQ*WIDTH]  packed Gray words, requester i at [i*WIDTH +: WIDTH]
//   req_ready  [N_REQ]        one-hot accept, only in IDLE, combinational
//   out_valid  decoded result valid
//   out_ready  downstream accepts result
//   out_bin    [WIDTH]        decoded binary value
//   out_id     [IDW]          requester that produced out_bin
//   busy       high whenever the FSM is not idle
module gray_conv_arbiter
   import gray_conv_arbiter_pkg::*;
#(
   parameter  int N_REQ = 4,
   parameter  int WIDTH = 4,
   localparam int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req_valid,
   input  logic [N_REQ*WIDTH-1:0] req_gray,
   output logic [N_REQ-1:0]       req_ready,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WIDTH-1:0]       out_bin,
   output logic [IDW-1:0]         out_id,
   output logic                   busy
);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   state_e           state_q,     state_d;
   logic [IDW-1:0]   rr_ptr_q,    rr_ptr_d;
   logic [WIDTH-1:0] gray_q,      gray_d;
   logic [IDW-1:0]   id_q,        id_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_bin_q,   out_bin_d;
   logic [IDW-1:0]   out_id_q,    out_id_d;

   // ------------------------------------------------------------------
   // Unpack the request words so the granted one can be picked by index.
   // ------------------------------------------------------------------
   logic [WIDTH-1:0] req_word [N_REQ];

   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign req_word[gi] = req_gray[gi*WIDTH +: WIDTH];
   end

   // ------------------------------------------------------------------
   // Shared decoder, always looking at the captured word.
   // ------------------------------------------------------------------
   logic [WIDTH-1:0] dec_bin;

   gray_decode_core #(
      .WIDTH (WIDTH)
   ) u_decode (
      .gray_i (gray_q),
      .bin_o  (dec_bin)
   );

   // ------------------------------------------------------------------
   // Round-robin search: first valid requester at or after rr_ptr_q,
   // wrapping modulo N_REQ. Index arithmetic is done in int and folded
   // back by a single subtract, which also works for non-power-of-two N_REQ.
   // ------------------------------------------------------------------
   logic           grant_found;
   logic [IDW-1:0] grant_idx;
   logic [IDW-1:0] grant_next;
   int             cand;
   logic [IDW-1:0] cand_idx;

   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = 0;
      cand_idx    = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = int'(rr_ptr_q) + k;
         if (cand >= N_REQ) begin
            cand = cand - N_REQ;
         end
         cand_idx = IDW'(cand);
         if (!grant_found && req_valid[cand_idx]) begin
            grant_found = 1'b1;
            grant_idx   = cand_idx;
         end
      end
   end

   // Pointer moves just past the winner so it becomes lowest priority next time.
   always_comb begin
      if (grant_idx == IDW'(N_REQ - 1)) begin
         grant_next = '0;
      end else begin
         grant_next = grant_idx + IDW'(1);
      end
   end

   // ------------------------------------------------------------------
   // FSM next-state and outputs
   // ------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      gray_d      = gray_q;
      id_d        = id_q;
      out_valid_d = out_valid_q;
      out_bin_d   = out_bin_q;
      out_id_d    = out_id_q;
      req_ready   = '0;

      case (state_q)
         ST_IDLE: begin
            if (grant_found) begin
               req_ready[grant_idx] = 1'b1;
               gray_d               = req_word[grant_idx];
               id_d                 = grant_idx;
               rr_ptr_d             = grant_next;
               state_d              = ST_CONV;
            end
         end

         ST_CONV: begin
            out_bin_d   = dec_bin;
            out_id_d    = id_q;
            out_valid_d = 1'b1;
            state_d     = ST_OUT;
         end

         ST_OUT: begin
            // out_valid_q is always set here; the explicit term keeps the
            // handshake readable as valid & ready.
            if (out_valid_q && out_ready) begin
               out_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         rr_ptr_q    <= '0;
         gray_q      <= '0;
         id_q        <= '0;
         out_valid_q <= 1'b0;
         out_bin_q   <= '0;
         out_id_q    <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         gray_q      <= gray_d;
         id_q        <= id_d;
         out_valid_q <= out_valid_d;
         out_bin_q   <= out_bin_d;
         out_id_q    <= out_id_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_bin   = out_bin_q;
   assign out_id    = out_id_q;
   assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Purpose : directed bench for gray_conv_arbiter with a transaction-level reference model.
// Latency : n/a.
// Backpr. : drives out_ready low for a stall window to exercise the OUT hold.
module tb_gray_conv_arbiter;

   localparam int N   = 4;
   localparam int W   = 4;
   localparam int IDW = 2;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [N-1:0]     req_valid = '0;
   logic [N*W-1:0]   req_gray  = '0;
   logic             out_ready = 1'b0;
   logic [N-1:0]     req_ready;
   logic             out_valid;
   logic [W-1:0]     out_bin;
   logic [IDW-1:0]   out_id;
   logic             busy;

   gray_conv_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_gray  (req_gray),
      .req_ready (req_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_bin   (out_bin),
      .out_id    (out_id),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int errors  = 0;
   int cyc     = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   // Binary bit i is the parity of all Gray bits at or above i.
   function automatic logic [W-1:0] m_decode(input logic [W-1:0] g);
      logic [W-1:0] b;
      for (int i = 0; i < W; i++) b[i] = ^(g >> i);
      return b;
   endfunction

   // First valid requester at or after ptr, wrapping; -1 when none.
   function automatic int m_pick(input logic [N-1:0] v, input int ptr);
      for (int k = 0; k < N; k++) begin
         if (v[(ptr + k) % N]) return (ptr + k) % N;
      end
      return -1;
   endfunction

   int           m_ptr  = 0;
   bit           m_busy = 0;
   int           m_age  = 0;
   int           exp_id [$];
   logic [W-1:0] exp_bin[$];
   int           gnt_log[$];
   int           gnt_cyc[$];
   int           o_id_log[$];
   logic [W-1:0] o_bin_log[$];
   int           o_cyc[$];

   always @(negedge clk) begin
      int g;
      logic [N-1:0] exp_rdy;
      cyc++;
      check("onehot0", 32'($onehot0(req_ready)), 32'd1);
      if (rst) begin
         m_ptr = 0; m_busy = 0; m_age = 0;
         exp_id.delete(); exp_bin.delete();
         check("rst_req_ready", 32'(req_ready), 32'd0);
         check("rst_out_valid", 32'(out_valid), 32'd0);
         check("rst_busy",      32'(busy),      32'd0);
         check("rst_out_bin",   32'(out_bin),   32'd0);
         check("rst_out_id",    32'(out_id),    32'd0);
      end else begin
         if (m_busy) m_age++;
         check("busy",      32'(busy),      32'(m_busy));
         check("out_valid", 32'(out_valid), 32'(m_busy && m_age >= 2));
         if (!m_busy) begin
            g       = m_pick(req_valid, m_ptr);
            exp_rdy = (g < 0) ? '0 : N'(1 << g);
            check("req_ready", 32'(req_ready), 32'(exp_rdy));
            if (g >= 0) begin
               exp_id.push_back(g);
               exp_bin.push_back(m_decode(req_gray[g*W +: W]));
               gnt_log.push_back(g);
               gnt_cyc.push_back(cyc);
               m_ptr  = (g + 1) % N;
               m_busy = 1;
               m_age  = 0;
            end
         end else begin
            check("req_ready_busy", 32'(req_ready), 32'd0);
            if (m_age >= 2 && exp_id.size() > 0) begin
               check("out_bin", 32'(out_bin), 32'(exp_bin[0]));
               check("out_id",  32'(out_id),  32'(exp_id[0]));
               if (out_ready) begin
                  o_id_log.push_back(exp_id[0]);
                  o_bin_log.push_back(exp_bin[0]);
                  o_cyc.push_back(cyc);
                  void'(exp_id.pop_front());
                  void'(exp_bin.pop_front());
                  m_busy = 0;
               end
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic set_gray(input int i, input logic [W-1:0] g);
      req_gray[i*W +: W] = g;
   endtask

   task automatic wait_grants(input int n);
      int t = 0;
      while (gnt_log.size() < n && t < 60) begin
         @(posedge clk); t++;
      end
      #1;
      check("grant_count", 32'(gnt_log.size()), 32'(n));
   endtask

   task automatic wait_outs(input int n);
      int t = 0;
      while (o_id_log.size() < n && t < 60) begin
         @(posedge clk); t++;
      end
      #1;
      check("out_count", 32'(o_id_log.size()), 32'(n));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int nb;
      int t;

      // ---- 1: reset, then idle for 10 cycles ----
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("t1_out_bin",   32'(out_bin),   32'd0);
      check("t1_out_id",    32'(out_id),    32'd0);
      check("t1_req_ready", 32'(req_ready), 32'd0);

      // ---- 2: single request from 0 ----
      out_ready = 1'b1;
      set_gray(0, 4'b0110);
      req_valid = 4'b0001;
      wait_grants(1);
      req_valid = '0;
      wait_outs(1);
      check("t2_grant",   32'(gnt_log[0]),   32'd0);
      check("t2_out_bin", 32'(o_bin_log[0]), 32'b0100);
      check("t2_out_id",  32'(o_id_log[0]),  32'd0);
      check("t2_latency", 32'(o_cyc[0] - gnt_cyc[0]), 32'd2);

      // bring the pointer back to 0 with a single grant to requester 3
      set_gray(3, 4'b1111);
      req_valid = 4'b1000;
      wait_grants(2);
      req_valid = '0;
      wait_outs(2);
      check("pre3_out_bin", 32'(o_bin_log[1]), 32'b1010);

      // ---- 3: all four held ----
      set_gray(0, 4'b0000);
      set_gray(1, 4'b0011);
      set_gray(2, 4'b1100);
      set_gray(3, 4'b1111);
      nb = gnt_log.size();
      req_valid = 4'b1111;
      wait_grants(nb + 5);
      req_valid = '0;
      wait_outs(nb + 5);
      begin
         int           eg[5] = '{0, 1, 2, 3, 0};
         logic [W-1:0] eb[5] = '{4'b0000, 4'b0010, 4'b1000, 4'b1010, 4'b0000};
         for (int i = 0; i < 5; i++) begin
            check("t3_grant",   32'(gnt_log[nb+i]),   32'(eg[i]));
            check("t3_out_bin", 32'(o_bin_log[nb+i]), 32'(eb[i]));
            if (i > 0) check("t3_spacing", 32'(gnt_cyc[nb+i] - gnt_cyc[nb+i-1]), 32'd3);
         end
      end

      // ---- 4: pointer to 3, then 1001 -> 3 then 0 ----
      req_valid = 4'b0100;
      wait_grants(gnt_log.size() + 1);
      req_valid = '0;
      wait_outs(o_id_log.size() + 1);
      nb = gnt_log.size();
      req_valid = 4'b1001;
      wait_grants(nb + 1);
      req_valid = 4'b0001;
      wait_grants(nb + 2);
      req_valid = '0;
      wait_outs(o_id_log.size() + 1);
      check("t4_first",  32'(gnt_log[nb]),   32'd3);
      check("t4_second", 32'(gnt_log[nb+1]), 32'd0);

      // ---- 5: output stall for 8 cycles ----
      out_ready = 1'b0;
      set_gray(1, 4'b1010);
      nb = gnt_log.size();
      req_valid = 4'b0010;
      wait_grants(nb + 1);
      req_valid = 4'b0100;
      t = 0;
      while (!out_valid && t < 10) begin
         @(negedge clk); t++;
      end
      check("t5_valid_seen", 32'(out_valid), 32'd1);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("t5_hold_bin",   32'(out_bin),   32'b1100);
         check("t5_hold_id",    32'(out_id),    32'd1);
         check("t5_hold_ready", 32'(req_ready), 32'd0);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      wait_outs(o_id_log.size() + 1);
      check("t5_out_bin", 32'(o_bin_log[o_bin_log.size()-1]), 32'b1100);
      wait_grants(nb + 2);
      req_valid = '0;
      check("t5_next_grant", 32'(gnt_log[nb+1]), 32'd2);
      wait_outs(o_id_log.size() + 1);

      // ---- 6: reset while in CONV ----
      nb = gnt_log.size();
      req_valid = 4'b1000;
      wait_grants(nb + 1);
      req_valid = '0;
      #2 rst = 1'b1;
      #1;
      check("t6_out_valid", 32'(out_valid), 32'd0);
      check("t6_busy",      32'(busy),      32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      nb = gnt_log.size();
      set_gray(0, 4'b0110);
      req_valid = 4'b0001;
      wait_grants(nb + 1);
      req_valid = '0;
      wait_outs(o_id_log.size() + 1);
      check("t6_grant",   32'(gnt_log[nb]), 32'd0);
      check("t6_out_bin", 32'(o_bin_log[o_bin_log.size()-1]), 32'b0100);
      check("t6_out_id",  32'(o_id_log[o_id_log.size()-1]),   32'd0);

      repeat (3) @(posedge clk);
      #1;
      check("scoreboard_empty", 32'(exp_id.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
